// File: rtl/dmem_pkg.sv
// Shared encodings and byte-lane helpers for the load/store data memory.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {ST_IDLE, ST_SPLIT} state_t;

  // Lanes beyond 3 are dropped, which is exactly the first half of a split access.
  function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [2:0] n);
    logic [7:0] m;
    m = (8'd1 << n) - 8'd1;
    m = m << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] bytes, input logic [2:0] n,
                                         input logic uns);
    logic [31:0] r;
    case (n)
      3'd1:    r = uns ? {24'h0, bytes[7:0]}  : {{24{bytes[7]}}, bytes[7:0]};
      3'd2:    r = uns ? {16'h0, bytes[15:0]} : {{16{bytes[15]}}, bytes[15:0]};
      default: r = bytes;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised RAM: asynchronous read, byte-enabled synchronous write.
module dmem_bank #(
   parameter int DEPTH_WORDS = 1024,
   parameter     INIT_FILE   = "",
   localparam int AW         = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/data_memory_lsu.sv
// Byte/half/word load-store unit; word-straddling accesses take two cycles.
//   state    | meaning
//   ST_IDLE  | accept request; aligned or rejected ones finish here
//   ST_SPLIT | second word of a misaligned access
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32,
  parameter     INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] a,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  output logic              ready,
  output logic              err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-2:0] DEPTH_L = (ADDR_W-1)'(DEPTH_WORDS);

  state_t            state;
  logic [31:0]       hold;
  logic [1:0]        off;
  logic [2:0]        n, n2, rem;
  logic [4:0]        sh_off;
  logic [5:0]        sh_rem;
  logic              mis, bad;
  logic [ADDR_W-2:0] last;
  logic [AW-1:0]     widx;
  logic [3:0]        be;
  logic [31:0]       wdata, rdata;

  assign off    = a[1:0];
  assign n      = (size == SZ_B) ? 3'd1 : (size == SZ_H) ? 3'd2 : 3'd4;
  assign mis    = ({1'b0, off} + n) > 3'd4;
  assign n2     = {1'b0, off} + n - 3'd4;
  assign rem    = 3'd4 - {1'b0, off};
  assign sh_off = {off, 3'b000};
  assign sh_rem = {rem, 3'b000};
  // Range check uses the word holding the last byte, one bit wider so it cannot wrap.
  assign last   = {1'b0, a[ADDR_W-1:2]} + (ADDR_W-1)'(mis);
  assign bad    = (size == 2'b11) || (last >= DEPTH_L);
  assign widx   = a[AW+1:2] + AW'(state == ST_SPLIT);

  dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS), .INIT_FILE(INIT_FILE)) u_bank (
    .clk   (clk),
    .be    (be),
    .addr  (widx),
    .wdata (wdata),
    .rdata (rdata)
  );

  always_comb begin
    ready = 1'b1;
    err   = 1'b0;
    rd    = '0;
    be    = '0;
    wdata = '0;
    if (!rst_n) begin
      ready = 1'b1;
    end else if (state == ST_IDLE) begin
      if (req) begin
        if (bad) begin
          err = 1'b1;
        end else begin
          ready = !mis;
          if (we) begin
            be    = lane_mask(off, n);
            wdata = wd << sh_off;
          end else if (!mis) begin
            rd = extend(rdata >> sh_off, n, uns);
          end
        end
      end
    end else if (req) begin
      if (we) begin
        be    = lane_mask(2'd0, n2);
        wdata = wd >> sh_rem;
      end else begin
        rd = extend(hold | (rdata << sh_rem), n, uns);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      hold  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req && !bad && mis) begin
            state <= ST_SPLIT;
            if (!we) hold <= rdata >> sh_off;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed plus randomized checks of the load/store unit against a byte-array model.
module tb_data_memory_lsu;

  localparam int DEPTH = 1024;
  localparam int AW    = 32;

  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] a = '0, wd = '0, rd;
  logic        ready, err;

  int vectors = 0, fails = 0;
  byte unsigned mm [4*DEPTH];

  always #5 clk = ~clk;

  data_memory_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
    .a(a), .wd(wd), .rd(rd), .ready(ready), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit m_err(input logic [1:0] s, input logic [31:0] ad);
    logic [63:0] lastb;
    if (s == 2'b11) return 1'b1;
    lastb = {32'b0, ad} + 64'(nbytes(s)) - 64'd1;
    return (lastb >> 2) >= 64'(DEPTH);
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] s, input bit u, input logic [31:0] ad);
    logic [31:0] v;
    int n;
    n = nbytes(s);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mm[ad + i];
    if (n < 4 && !u && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic m_store(input logic [1:0] s, input logic [31:0] ad, input logic [31:0] d,
                         input int upto);
    for (int i = 0; i < nbytes(s) && i < upto; i++) mm[ad + i] = d[8*i +: 8];
  endtask

  task automatic access(input string tag, input bit w, input logic [1:0] s, input bit u,
                        input logic [31:0] ad, input logic [31:0] d);
    bit e, mis;
    logic [31:0] exp;
    int n, off;
    n   = nbytes(s);
    off = int'(ad[1:0]);
    e   = m_err(s, ad);
    mis = !e && (off + n > 4);
    exp = (e || w) ? 32'h0 : m_load(s, u, ad);
    req = 1'b1; we = w; size = s; uns = u; a = ad; wd = d;
    @(negedge clk);
    check({tag, ".ready"}, 32'(ready), mis ? 32'd0 : 32'd1);
    check({tag, ".err"}, 32'(err), 32'(e));
    if (!mis) check({tag, ".rd"}, rd, exp);
    @(posedge clk); #1;
    if (mis) begin
      @(negedge clk);
      check({tag, ".ready2"}, 32'(ready), 32'd1);
      check({tag, ".err2"}, 32'(err), 32'd0);
      check({tag, ".rd2"}, rd, exp);
      @(posedge clk); #1;
    end
    if (!e && w) m_store(s, ad, d, 4);
    req = 1'b0;
  endtask

  task automatic idle_cycle(input string tag);
    req = 1'b0; we = 1'($urandom); size = 2'($urandom); a = $urandom_range(0, 255);
    wd = $urandom;
    @(negedge clk);
    check({tag, ".ready"}, 32'(ready), 32'd1);
    check({tag, ".err"}, 32'(err), 32'd0);
    check({tag, ".rd"}, rd, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    req = 1'b1; we = 1'b0; size = 2'b10; a = 32'h43;
    #3;
    check("reset.ready", 32'(ready), 32'd1);
    check("reset.err", 32'(err), 32'd0);
    check("reset.rd", rd, 32'd0);
    req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < DEPTH; k++) access("clear", 1'b1, 2'b10, 1'b0, 32'(4*k), 32'h0);

    access("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    access("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    access("sb21", 1'b1, 2'b00, 1'b0, 32'h21, 32'h80);
    access("lb21", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
    access("lbu21", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
    access("lh20", 1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
    access("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    access("sw43", 1'b1, 2'b10, 1'b0, 32'h43, 32'h11223344);
    access("lw40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    access("lw44", 1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
    access("lw43", 1'b0, 2'b10, 1'b0, 32'h43, 32'h0);
    access("lhu47", 1'b0, 2'b01, 1'b1, 32'h47, 32'h0);
    access("lh45", 1'b0, 2'b01, 1'b0, 32'h45, 32'h0);
    access("lh43", 1'b0, 2'b01, 1'b0, 32'h43, 32'h0);

    access("ill_st", 1'b1, 2'b11, 1'b0, 32'h10, 32'h0BADF00D);
    access("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    access("lw_end", 1'b0, 2'b10, 1'b0, 32'(4*DEPTH), 32'h0);
    access("sh_cross", 1'b1, 2'b01, 1'b0, 32'(4*DEPTH-1), 32'hA5A5);
    access("lw_last", 1'b0, 2'b10, 1'b0, 32'(4*DEPTH-4), 32'h0);
    access("lh_cross", 1'b0, 2'b01, 1'b0, 32'(4*DEPTH-1), 32'h0);
    access("lb_lastb", 1'b0, 2'b00, 1'b1, 32'(4*DEPTH-1), 32'h0);

    // Reset lands between the two halves of a split store.
    req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; a = 32'h43; wd = 32'hAABBCCDD;
    @(negedge clk);
    check("rst_split.ready1", 32'(ready), 32'd0);
    @(posedge clk); #1;
    m_store(2'b10, 32'h43, 32'hAABBCCDD, 1);
    rst_n = 1'b0;
    #1;
    check("rst_split.ready", 32'(ready), 32'd1);
    check("rst_split.rd", rd, 32'd0);
    req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    access("post_rst_lw40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    access("post_rst_lw44", 1'b0, 2'b10, 1'b0, 32'h44, 32'h0);

    // Request dropped while the split load waits for its second word.
    req = 1'b1; we = 1'b0; size = 2'b10; a = 32'h45;
    @(negedge clk);
    check("abort.ready1", 32'(ready), 32'd0);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("abort.ready2", 32'(ready), 32'd1);
    check("abort.rd", rd, 32'd0);
    check("abort.err", 32'(err), 32'd0);
    @(posedge clk); #1;
    access("abort.next_lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    idle_cycle("idle");

    for (int t = 0; t < 500; t++) begin
      int r;
      logic [1:0] s;
      logic [31:0] ad;
      r  = $urandom_range(0, 19);
      s  = (r == 1) ? 2'b11 : 2'($urandom_range(0, 2));
      ad = (r == 2) ? 32'(4*DEPTH - 8 + $urandom_range(0, 11)) : 32'($urandom_range(0, 255));
      if (r == 0) idle_cycle("rnd_idle");
      else access("rnd", 1'($urandom), s, 1'($urandom), ad, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
